// File: rtl/nbit_4ch_rr_scheduler.sv
// nbit_4ch_rr_scheduler: buffers four producer channels and feeds a 4x1 mux with valid/ready arbitration.
// Define SCHED_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority with channel 0 highest.
module nbit_4ch_rr_scheduler #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   in_valid,
   input  logic [N-1:0] in_data_a,
   input  logic [N-1:0] in_data_b,
   input  logic [N-1:0] in_data_c,
   input  logic [N-1:0] in_data_d,
   output logic [3:0]   in_ready,
   output logic [N-1:0] A,
   output logic [N-1:0] B,
   output logic [N-1:0] C,
   output logic [N-1:0] D,
   output logic [1:0]   S,
   output logic         out_valid,
   input  logic         out_ready
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_n;
   logic [3:0] full, load, rel, cand;
   logic [1:0] s_q, s_n, base;

   function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
      pick = start;
      for (int i = 3; i >= 0; i--)
         if (req[start + 2'(i)]) pick = start + 2'(i);
   endfunction

   assign load = in_valid & in_ready;

`ifdef SCHED_ROUND_ROBIN_EN
   logic [1:0] ptr;
   // After a transfer the search starts just past the channel that was served
   assign base = (state == GRANT) ? s_q + 2'd1 : ptr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= 2'd0;
      else if (|rel) ptr <= s_q + 2'd1;
`else
   assign base = 2'd0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         s_q   <= 2'd0;
      end else begin
         state <= state_n;
         s_q   <= s_n;
      end

   always_comb begin
      rel     = (state == GRANT && out_ready) ? 4'b0001 << s_q : 4'b0000;
      cand    = (state == GRANT && !out_ready) ? 4'b0000 : full & ~rel;
      state_n = state;
      s_n     = s_q;
      if (state == IDLE || out_ready) begin
         state_n = |cand ? GRANT : IDLE;
         s_n     = |cand ? pick(cand, base) : s_q;
      end
   end

   always_comb begin
      out_valid = (state == GRANT);
      S         = s_q;
   end

   // in_ready lags a release by one cycle but drops on the load edge itself
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         full     <= 4'b0000;
         in_ready <= 4'b0000;
         A        <= '0;
         B        <= '0;
         C        <= '0;
         D        <= '0;
      end else begin
         full     <= (full & ~rel) | load;
         in_ready <= ~(full | load);
         if (load[0]) A <= in_data_a;
         if (load[1]) B <= in_data_b;
         if (load[2]) C <= in_data_c;
         if (load[3]) D <= in_data_d;
      end
endmodule

// File: tb/tb_nbit_4ch_rr_scheduler.sv
// tb_nbit_4ch_rr_scheduler: directed and randomized checks of the scheduler against a behavioural model.
module tb_nbit_4ch_rr_scheduler;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] in_valid;
   logic [7:0] in_data_a, in_data_b, in_data_c, in_data_d;
   logic [3:0] in_ready;
   logic [7:0] A, B, C, D, y;
   logic [1:0] S;
   logic       out_valid, out_ready;
   logic       check_en = 1'b0;
   int         n_cmp = 0, n_bad = 0;

   nbit_4ch_rr_scheduler #(.N(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .in_data_a(in_data_a), .in_data_b(in_data_b), .in_data_c(in_data_c), .in_data_d(in_data_d),
      .in_ready(in_ready), .A(A), .B(B), .C(C), .D(D), .S(S),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;
   assign y = (S == 2'd0) ? A : (S == 2'd1) ? B : (S == 2'd2) ? C : D;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: per-channel occupancy, held word, acceptance flag and the currently granted channel (-1 = none)
   logic [7:0] m_buf[4];
   bit         m_full[4], m_rdy[4], ld[4], avail[4];
   int         m_gnt, m_ptr, start, nxt;
   bit         xfer;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            m_buf[k] = 8'h00; m_full[k] = 0; m_rdy[k] = 0;
         end
         m_gnt = -1;
         m_ptr = 0;
      end else begin
         xfer = (m_gnt >= 0) && out_ready;
         for (int k = 0; k < 4; k++) begin
            ld[k]    = in_valid[k] && m_rdy[k];
            avail[k] = m_full[k] && !(xfer && k == m_gnt);
         end
         start = 0;
`ifdef SCHED_ROUND_ROBIN_EN
         start = xfer ? (m_gnt + 1) % 4 : m_ptr;
         if (xfer) m_ptr = (m_gnt + 1) % 4;
`endif
         nxt = -1;
         for (int o = 3; o >= 0; o--)
            if (avail[(start + o) % 4]) nxt = (start + o) % 4;
         if (m_gnt < 0 || out_ready) m_gnt = nxt;
         for (int k = 0; k < 4; k++) begin
            m_rdy[k]  = !m_full[k] && !ld[k];
            m_full[k] = avail[k] || ld[k];
         end
         if (ld[0]) m_buf[0] = in_data_a;
         if (ld[1]) m_buf[1] = in_data_b;
         if (ld[2]) m_buf[2] = in_data_c;
         if (ld[3]) m_buf[3] = in_data_d;
      end
   end

   always @(negedge clk)
      if (check_en) begin
         chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_gnt >= 0});
         chk("m_in_ready", {28'b0, in_ready}, {28'b0, m_rdy[3], m_rdy[2], m_rdy[1], m_rdy[0]});
         chk("m_buffers", {A, B, C, D}, {m_buf[0], m_buf[1], m_buf[2], m_buf[3]});
         if (m_gnt >= 0) begin
            chk("m_S", {30'b0, S}, m_gnt);
            chk("m_Y", {24'b0, y}, {24'b0, m_buf[m_gnt]});
         end
      end

   task automatic step();
      @(negedge clk);
   endtask

   logic [7:0] exp4[4];

   initial begin
      exp4 = '{8'h55, 8'hAA, 8'hF0, 8'h0F};
      in_valid = 4'h0; out_ready = 1'b0;
      in_data_a = 8'h00; in_data_b = 8'h00; in_data_c = 8'h00; in_data_d = 8'h00;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", {28'b0, in_ready}, 32'h0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      step(); step();
      rst_n = 1'b1;
      check_en = 1'b1;
      step();
      chk("rel_in_ready", {28'b0, in_ready}, 32'hF);

      // single channel
      in_valid = 4'b0100; in_data_c = 8'hF0; out_ready = 1'b1;
      step(); in_valid = 4'b0000;
      chk("single_not_yet", {31'b0, out_valid}, 32'h0);
      step();
      chk("single_valid", {31'b0, out_valid}, 32'h1);
      chk("single_S", {30'b0, S}, 32'h2);
      chk("single_Y", {24'b0, y}, 32'hF0);
      step();
      chk("single_done", {31'b0, out_valid}, 32'h0);
      chk("single_rdy_lag", {31'b0, in_ready[2]}, 32'h0);
      step();
      chk("single_reload", {31'b0, in_ready[2]}, 32'h1);

      // all four at once
      in_valid = 4'b1111;
      in_data_a = 8'h55; in_data_b = 8'hAA; in_data_c = 8'hF0; in_data_d = 8'h0F;
      step(); in_valid = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("all4_S", {30'b0, S}, i);
         chk("all4_Y", {24'b0, y}, {24'b0, exp4[i]});
      end
      step();
      chk("all4_done", {31'b0, out_valid}, 32'h0);

      // backpressure, refill of another channel must not preempt
      out_ready = 1'b0;
      in_valid = 4'b0010; in_data_b = 8'hAA;
      step(); in_valid = 4'b0000;
      step();
      in_valid = 4'b0001; in_data_a = 8'h55;
      for (int i = 0; i < 5; i++) begin
         chk("bp_S", {30'b0, S}, 32'h1);
         chk("bp_Y", {24'b0, y}, 32'hAA);
         step(); in_valid = 4'b0000;
      end
      out_ready = 1'b1;
      step();
      chk("bp_next_S", {30'b0, S}, 32'h0);
      chk("bp_next_Y", {24'b0, y}, 32'h55);
      step();
      chk("bp_done", {31'b0, out_valid}, 32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = 4'($urandom);
         in_data_a = 8'($urandom); in_data_b = 8'($urandom);
         in_data_c = 8'($urandom); in_data_d = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // reset while a grant is stalled
      out_ready = 1'b0; in_valid = 4'b1111;
      step(); in_valid = 4'b0000;
      step(); step();
      chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
      chk("mid_rst_S", {30'b0, S}, 32'h0);
      chk("mid_rst_bufs", {A, B, C, D}, 32'h0);
      chk("mid_rst_rdy", {28'b0, in_ready}, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_rdy", {28'b0, in_ready}, 32'hF);
      chk("post_rst_valid", {31'b0, out_valid}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
